// File: rtl/down_timer.sv
// Loadable down-counting interval timer: load a value, start, count to zero,
// pulse o_done on expiry, optionally reload and keep running as a periodic tick.
module down_timer #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_sclear,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_start,
   input  logic             i_pause,
   input  logic             i_reload_en,
   output logic [WIDTH-1:0] o_counter,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_zero
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;

   always_ff @(posedge i_clk) begin
      if (i_sclear) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (i_load) begin
         cnt_d    = i_data;
         reload_d = i_data;
         state_d  = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start && cnt_q != '0) state_d = RUN;
            end
            RUN: begin
               if (!i_pause) begin
                  if (cnt_q > WIDTH'(1)) begin
                     cnt_d = cnt_q - WIDTH'(1);
                  end else if (cnt_q == WIDTH'(1)) begin
                     done_d = 1'b1;
                     if (i_reload_en) begin
                        cnt_d = reload_q;
                     end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                     end
                  end else begin
                     // Unreachable in normal use; never let a zero count wrap.
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign o_counter = cnt_q;
   assign o_busy    = (state_q == RUN);
   assign o_done    = done_q;
   assign o_zero    = (cnt_q == '0);

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer (WIDTH=8): vector table for short sequences,
// hand-written loops for long countdowns, pause, abort and reload periods.
module tb_down_timer;

   logic       clk = 1'b0;
   logic       sclear, load, start, pause, reload_en;
   logic [7:0] data;
   logic [7:0] counter;
   logic       busy, done, zero;

   int checks = 0;
   int errors = 0;

   down_timer #(.WIDTH(8)) dut (
      .i_clk       (clk),
      .i_sclear    (sclear),
      .i_load      (load),
      .i_data      (data),
      .i_start     (start),
      .i_pause     (pause),
      .i_reload_en (reload_en),
      .o_counter   (counter),
      .o_busy      (busy),
      .o_done      (done),
      .o_zero      (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       sc, ld;
      logic [7:0] d;
      logic       st, pa, re;
      logic [7:0] ec;
      logic       eb, ed, ez;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic sc, logic ld, logic [7:0] d, logic st, logic pa,
                               logic re, logic [7:0] ec, logic eb, logic ed, logic ez);
      vec_t v;
      v.sc = sc; v.ld = ld; v.d = d; v.st = st; v.pa = pa; v.re = re;
      v.ec = ec; v.eb = eb; v.ed = ed; v.ez = ez;
      return v;
   endfunction

   // Drive one cycle of inputs, then sample just after the rising edge.
   task automatic step(input logic sc, input logic ld, input logic [7:0] d,
                       input logic st, input logic pa, input logic re);
      sclear = sc; load = ld; data = d; start = st; pause = pa; reload_en = re;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int idx, input logic [7:0] ec,
                        input logic eb, input logic ed, input logic ez);
      checks++;
      if (counter !== ec || busy !== eb || done !== ed || zero !== ez) begin
         errors++;
         $display("FAIL %s[%0d]: got cnt=%0d busy=%b done=%b zero=%b, want cnt=%0d busy=%b done=%b zero=%b",
                  name, idx, counter, busy, done, zero, ec, eb, ed, ez);
      end
   endtask

   initial begin
      sclear = 1'b0; load = 1'b0; data = '0; start = 1'b0; pause = 1'b0; reload_en = 1'b0;
      @(negedge clk);

      // sc ld d st pa re | cnt busy done zero
      vecs.push_back(mk(1,0,  0,0,0,0,  0,0,0,1)); // reset state
      vecs.push_back(mk(0,0,  0,1,0,0,  0,0,0,1)); // start at zero ignored
      vecs.push_back(mk(0,1,  3,0,0,1,  3,0,0,0)); // reload period 3
      vecs.push_back(mk(0,0,  0,1,0,1,  3,1,0,0));
      vecs.push_back(mk(0,0,  0,0,0,1,  2,1,0,0));
      vecs.push_back(mk(0,0,  0,0,0,1,  1,1,0,0));
      vecs.push_back(mk(0,0,  0,0,0,1,  3,1,1,0));
      vecs.push_back(mk(0,0,  0,0,0,1,  2,1,0,0));
      vecs.push_back(mk(0,0,  0,0,0,1,  1,1,0,0));
      vecs.push_back(mk(0,0,  0,0,0,1,  3,1,1,0));
      vecs.push_back(mk(0,0,  0,0,0,0,  2,1,0,0)); // drop reload_en
      vecs.push_back(mk(0,0,  0,0,0,0,  1,1,0,0));
      vecs.push_back(mk(0,0,  0,0,0,0,  0,0,1,1));
      vecs.push_back(mk(0,0,  0,0,0,0,  0,0,0,1));
      vecs.push_back(mk(0,1, 10,0,0,0, 10,0,0,0)); // mid-run sclear at 7
      vecs.push_back(mk(0,0,  0,1,0,0, 10,1,0,0));
      vecs.push_back(mk(0,0,  0,0,0,0,  9,1,0,0));
      vecs.push_back(mk(0,0,  0,0,0,0,  8,1,0,0));
      vecs.push_back(mk(0,0,  0,0,0,0,  7,1,0,0));
      vecs.push_back(mk(1,0,  0,0,0,0,  0,0,0,1));
      vecs.push_back(mk(1,1,  9,0,0,0,  0,0,0,1)); // sclear beats load
      vecs.push_back(mk(0,1,  2,0,0,0,  2,0,0,0)); // start in RUN ignored
      vecs.push_back(mk(0,0,  0,1,0,0,  2,1,0,0));
      vecs.push_back(mk(0,0,  0,1,0,0,  1,1,0,0));
      vecs.push_back(mk(0,0,  0,1,0,0,  0,0,1,1));
      vecs.push_back(mk(0,1,  1,0,0,1,  1,0,0,0)); // N=1 reload: done every cycle
      vecs.push_back(mk(0,0,  0,1,0,1,  1,1,0,0));
      vecs.push_back(mk(0,0,  0,0,0,1,  1,1,1,0));
      vecs.push_back(mk(0,0,  0,0,0,1,  1,1,1,0));
      vecs.push_back(mk(0,0,  0,0,0,0,  0,0,1,1));
      vecs.push_back(mk(0,0,  0,0,0,0,  0,0,0,1));

      foreach (vecs[i]) begin
         step(vecs[i].sc, vecs[i].ld, vecs[i].d, vecs[i].st, vecs[i].pa, vecs[i].re);
         check("vec", i, vecs[i].ec, vecs[i].eb, vecs[i].ed, vecs[i].ez);
      end

      // Basic countdown from 20, start at edge k, expiry at k+20.
      step(0,1,20,0,0,0); check("c1_load", 0, 20,0,0,0);
      step(0,0, 0,1,0,0); check("c1_start", 0, 20,1,0,0);
      for (int i = 1; i <= 20; i++) begin
         step(0,0,0,0,0,0);
         check("c1_run", i, 8'(20 - i), i < 20, i == 20, i == 20);
      end
      step(0,0,0,0,0,0); check("c1_after", 0, 0,0,0,1);

      // Pause for 5 cycles at 6: expiry slips by exactly 5 edges.
      step(0,1,10,0,0,0); check("c3_load", 0, 10,0,0,0);
      step(0,0, 0,1,0,0); check("c3_start", 0, 10,1,0,0);
      for (int i = 1; i <= 4; i++) begin
         step(0,0,0,0,0,0); check("c3_pre", i, 8'(10 - i), 1,0,0);
      end
      for (int i = 0; i < 5; i++) begin
         step(0,0,0,0,1,1); check("c3_pause", i, 6,1,0,0);
      end
      for (int i = 1; i <= 6; i++) begin
         step(0,0,0,0,0,0);
         check("c3_post", i, 8'(6 - i), i < 6, i == 6, i == 6);
      end

      // Load during RUN aborts with no done pulse.
      step(0,1,20,0,0,0); check("c4_load", 0, 20,0,0,0);
      step(0,0, 0,1,0,0); check("c4_start", 0, 20,1,0,0);
      for (int i = 1; i <= 8; i++) begin
         step(0,0,0,0,0,0); check("c4_run", i, 8'(20 - i), 1,0,0);
      end
      step(0,1,5,0,0,0); check("c4_abort", 0, 5,0,0,0);
      step(0,0,0,0,0,0); check("c4_idle", 0, 5,0,0,0);
      step(0,0,0,1,0,0); check("c4_start2", 0, 5,1,0,0);
      for (int i = 1; i <= 5; i++) begin
         step(0,0,0,0,0,0);
         check("c4_run2", i, 8'(5 - i), i < 5, i == 5, i == 5);
      end
      step(0,0,0,0,0,0); check("c4_after", 0, 0,0,0,1);

      // Max value 255: no wrap, single done.
      step(0,1,255,0,0,0); check("c6_load", 0, 255,0,0,0);
      step(0,0,  0,1,0,0); check("c6_start", 0, 255,1,0,0);
      for (int i = 1; i <= 255; i++) begin
         step(0,0,0,0,0,0);
         check("c6_run", i, 8'(255 - i), i < 255, i == 255, i == 255);
      end
      step(0,0,0,0,0,0); check("c6_after", 0, 0,0,0,1);

      // Max value with reload: done every 255 cycles.
      step(0,1,255,0,0,1); check("c6r_load", 0, 255,0,0,0);
      step(0,0,  0,1,0,1); check("c6r_start", 0, 255,1,0,0);
      for (int i = 1; i <= 510; i++) begin
         step(0,0,0,0,0,1);
         check("c6r_run", i, (i % 255 == 0) ? 8'd255 : 8'(255 - (i % 255)), 1, i % 255 == 0, 0);
      end
      step(1,0,0,0,0,0); check("final_clr", 0, 0,0,0,1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counting interval timer; the counting/consuming counterpart of the team's loadable up-counter.
- Software or a controller loads a count value and starts it.
- The block decrements to zero and signals expiry with a one-cycle done pulse.
- Optional auto-reload turns it into a periodic tick generator for downstream sequencing logic.

Parameters:
WIDTH, 8, counter and load-data width in bits (legal range 2..32).

Ports:
i_clk  input  1  system clock; all state changes on rising edge.
i_sclear  input  1  synchronous reset, active-high.
i_load  input  1  load strobe; copies i_data into counter and reload register.
i_data  input  WIDTH  load value.
i_start  input  1  start strobe; begins countdown from current counter value.
i_pause  input  1  level; while high in RUN the counter holds.
i_reload_en  input  1  level; when high at expiry, counter reloads and keeps running.
o_counter  output  WIDTH  current count (registered).
o_busy  output  1  high while in RUN (registered).
o_done  output  1  one-cycle expiry pulse (registered).
o_zero  output  1  combinational: o_counter == 0.

Behaviour:
- Clock and reset: one clock domain, i_clk. Reset is synchronous and active-high on i_sclear, sampled at the rising edge.
- Reset values: o_counter=0, reload register=0, state=IDLE, o_busy=0, o_done=0. o_zero therefore reads 1.
- States: IDLE and RUN only. o_busy = (state==RUN).
- Priority per edge: i_sclear > i_load > i_start > count/pause.
- o_done default: 0 on every edge unless the expiry condition below sets it. It is never high for two consecutive cycles except under reload with value 1.

Load:
- In any state: o_counter<=i_data, reload<=i_data, state<=IDLE, o_done<=0.
- A load during RUN aborts the run silently, with no done pulse.

IDLE:
- i_start=1 and o_counter!=0: state<=RUN. The counter is unchanged at this edge.
- i_start=1 and o_counter==0: ignored. Stay in IDLE, no done pulse.

RUN, i_pause=1:
- Counter, state and reload register all hold.
- o_busy stays 1; o_done=0.

RUN, i_pause=0:
- o_counter>1: o_counter<=o_counter-1.
- o_counter==1 and i_reload_en=0: o_counter<=0, o_done<=1, state<=IDLE. o_busy falls in the same cycle o_done rises.
- o_counter==1 and i_reload_en=1: o_counter<=reload, o_done<=1, state stays RUN.

Timing and arithmetic:
- Latency: start sampled at edge k; expiry at edge k+N for load value N, with no pause.
- Reload period is exactly N cycles; with N=1, o_done is high every cycle.
- i_start while in RUN is ignored.
- i_reload_en is sampled only at the expiry edge.
- Arithmetic is unsigned. The counter never decrements below 0 and never wraps to 2^WIDTH-1.
- The maximum load value 2^WIDTH-1 must count correctly.

Test Plan:
1. WIDTH=8. Reset, load 20, start at edge k, pause=0, reload_en=0.
   -> o_counter 20 at k, then 19..0 on edges k+1..k+20.
   -> o_done=1 only in the cycle after edge k+20.
   -> o_busy 1 from k to k+20, then 0. o_zero=1 at end.
2. Load 3, reload_en=1, start.
   -> o_counter sequence 3,2,1,3,2,1,...
   -> o_done high exactly in the cycles where the counter has just reloaded to 3, i.e. every 3rd cycle. o_busy stays 1.
   -> Drop reload_en: the next expiry goes to 0/IDLE.
3. Load 10, start, hold i_pause for 5 cycles at counter=6.
   -> o_counter stays 6 for those 5 cycles, o_busy=1, o_done=0.
   -> Expiry is delayed by exactly 5 cycles versus case 1 timing.
4. Load 20, start, at counter=12 assert i_load with i_data=5.
   -> Next cycle o_counter=5, o_busy=0, no o_done pulse.
   -> A subsequent start counts 5..0 with a single done pulse.
5. Three sub-cases on corner conditions:
   - Start with counter=0 -> no state change, o_done stays 0.
   - Mid-run i_sclear at counter=7 -> next cycle o_counter=0, o_busy=0, o_done=0.
   - Simultaneous i_sclear and i_load -> reset wins.
6. Load 255, start.
   -> 255 decrements to 0 with no wrap; exactly one o_done after 255 cycles.
   -> With reload_en=1, the counter reloads to 255 and o_done recurs every 255 cycles.
